instr_fetch_stage: RTL and testbench

INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

---
 rtl/instr_fetch_stage.sv | 98 +++++++++
 tb/tb_instr_fetch_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC register, on-chip instruction memory with a program-load
// write port, one-cycle fetch, stall/redirect handling and a HALT state on HALT_WORD.
module instr_fetch_stage #(
    parameter int          IMEM_DEPTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
    localparam int         AW         = $clog2(IMEM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    input  logic          imem_we,
    input  logic [AW-1:0] imem_waddr,
    input  logic [31:0]   imem_wdata,
    output logic [31:0]   if_instr,
    output logic [31:0]   if_pc,
    output logic          if_valid,
    output logic          halted
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    logic [31:0] imem [IMEM_DEPTH];

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] if_instr_q;
    logic [31:0] if_pc_q;
    logic        if_valid_q;
    logic        halted_q;

    // Index by truncation so PCs past the end of memory alias back to the start.
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_word;

    assign rd_idx  = pc_q[AW+1:2];
    assign rd_word = imem[rd_idx];

    // Program-load port: deliberately independent of rst so code can be loaded in reset.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC & ~32'h3;
            if_instr_q <= 32'h0;
            if_pc_q    <= 32'h0;
            if_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else if (redirect) begin
            // Redirect beats stall and halt; the cleared output is the single bubble.
            state_q    <= RUN;
            pc_q       <= redirect_pc & ~32'h3;
            if_instr_q <= 32'h0;
            if_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else if (!stall) begin
            case (state_q)
                RUN: begin
                    if_instr_q <= rd_word;
                    if_pc_q    <= pc_q;
                    if (rd_word == HALT_WORD) begin
                        if_valid_q <= 1'b0;
                        halted_q   <= 1'b1;
                        state_q    <= HALT;
                    end else begin
                        if_valid_q <= 1'b1;
                        pc_q       <= pc_q + 32'd4;
                    end
                end
                HALT: begin
                    if_instr_q <= 32'h0;
                    if_valid_q <= 1'b0;
                    halted_q   <= 1'b1;
                end
                default: begin
                    state_q    <= RUN;
                    if_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign if_instr = if_instr_q;
    assign if_pc    = if_pc_q;
    assign if_valid = if_valid_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed testbench for instr_fetch_stage: sequential fetch, stall, redirect bubble,
// index wrap, halt/resume, same-cycle write/read and reset recovery.
module tb_instr_fetch_stage;

    localparam int          DEPTH = 32;
    localparam int          AW    = 5;
    localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic [31:0]   if_instr;
    logic [31:0]   if_pc;
    logic          if_valid;
    logic          halted;

    int checks = 0;
    int errors = 0;

    instr_fetch_stage #(
        .IMEM_DEPTH(DEPTH),
        .RESET_PC  (32'h0000_0000),
        .HALT_WORD (HALTW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_valid   (if_valid),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] w(input int i);
        return 32'hA000_0000 | i;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            imem_we = 1'b1; imem_waddr = AW'(i); imem_wdata = w(i);
            tick();
        end
        imem_we = 1'b0;
        checks++;
        if ({if_valid, halted, if_pc, if_instr} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_state: valid=%0b halted=%0b pc=%h instr=%h, required all zero",
                     if_valid, halted, if_pc, if_instr);
        end
        $display("reset: valid=%0b halted=%0b pc=%h instr=%h", if_valid, halted, if_pc, if_instr);
    endtask

    task automatic test_sequential_and_stall();
        logic [31:0] exp_pc [6];
        logic [31:0] exp_in [6];
        logic        stl [6];
        exp_pc = '{32'h0, 32'h4, 32'h4, 32'h4, 32'h4, 32'h8};
        exp_in = '{w(0), w(1), w(1), w(1), w(1), w(2)};
        stl    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            stall = stl[i];
            tick();
            checks++;
            if ({if_valid, if_pc, if_instr} !== {1'b1, exp_pc[i], exp_in[i]}) begin
                errors++;
                $display("FAIL seq_stall[%0d]: valid=%0b pc=%h instr=%h, required valid=1 pc=%h instr=%h",
                         i, if_valid, if_pc, if_instr, exp_pc[i], exp_in[i]);
            end
            $display("seq_stall[%0d]: stall=%0b valid=%0b pc=%h instr=%h", i, stl[i], if_valid, if_pc, if_instr);
        end
        stall = 1'b0;
        tick();
        checks++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'hC, w(3)}) begin
            errors++;
            $display("FAIL seq_d: valid=%0b pc=%h instr=%h, required 1/0000000c/%h", if_valid, if_pc, if_instr, w(3));
        end
        $display("seq_d: valid=%0b pc=%h instr=%h", if_valid, if_pc, if_instr);
    endtask

    task automatic test_redirect_bubble();
        redirect = 1'b1; redirect_pc = 32'h11; stall = 1'b1;
        tick();
        checks++;
        if ({if_valid, if_instr} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL redirect_bubble: valid=%0b instr=%h, required 0/00000000", if_valid, if_instr);
        end
        $display("redirect_bubble: valid=%0b instr=%h", if_valid, if_instr);
        redirect = 1'b0; stall = 1'b0;
        tick();
        checks++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h10, w(4)}) begin
            errors++;
            $display("FAIL redirect_target: valid=%0b pc=%h instr=%h, required 1/00000010/%h", if_valid, if_pc, if_instr, w(4));
        end
        $display("redirect_target: valid=%0b pc=%h instr=%h", if_valid, if_pc, if_instr);
        tick();
        checks++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h14, w(5)}) begin
            errors++;
            $display("FAIL redirect_next: valid=%0b pc=%h instr=%h, required 1/00000014/%h", if_valid, if_pc, if_instr, w(5));
        end
        $display("redirect_next: valid=%0b pc=%h instr=%h", if_valid, if_pc, if_instr);
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'h7C;
        tick();
        redirect = 1'b0;
        tick();
        checks++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h7C, w(31)}) begin
            errors++;
            $display("FAIL wrap_last: valid=%0b pc=%h instr=%h, required 1/0000007c/%h", if_valid, if_pc, if_instr, w(31));
        end
        $display("wrap_last: valid=%0b pc=%h instr=%h", if_valid, if_pc, if_instr);
        tick();
        checks++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h80, w(0)}) begin
            errors++;
            $display("FAIL wrap_first: valid=%0b pc=%h instr=%h, required 1/00000080/%h", if_valid, if_pc, if_instr, w(0));
        end
        $display("wrap_first: valid=%0b pc=%h instr=%h", if_valid, if_pc, if_instr);
    endtask

    task automatic test_halt();
        redirect = 1'b1; redirect_pc = 32'h0;
        imem_we = 1'b1; imem_waddr = AW'(2); imem_wdata = HALTW;
        tick();
        redirect = 1'b0; imem_we = 1'b0;
        tick();
        tick();
        checks++;
        if ({if_valid, if_pc, if_instr, halted} !== {1'b1, 32'h4, w(1), 1'b0}) begin
            errors++;
            $display("FAIL halt_pre: valid=%0b pc=%h instr=%h halted=%0b, required 1/00000004/%h/0",
                     if_valid, if_pc, if_instr, halted, w(1));
        end
        tick();
        checks++;
        if ({if_valid, halted, if_pc} !== {1'b0, 1'b1, 32'h8}) begin
            errors++;
            $display("FAIL halt_enter: valid=%0b halted=%0b pc=%h, required 0/1/00000008", if_valid, halted, if_pc);
        end
        $display("halt_enter: valid=%0b halted=%0b pc=%h", if_valid, halted, if_pc);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({if_valid, halted, if_pc, if_instr} !== {1'b0, 1'b1, 32'h8, 32'h0}) begin
                errors++;
                $display("FAIL halt_hold[%0d]: valid=%0b halted=%0b pc=%h instr=%h, required 0/1/00000008/00000000",
                         i, if_valid, halted, if_pc, if_instr);
            end
            $display("halt_hold[%0d]: valid=%0b halted=%0b pc=%h instr=%h", i, if_valid, halted, if_pc, if_instr);
        end
        redirect = 1'b1; redirect_pc = 32'h0;
        tick();
        redirect = 1'b0;
        checks++;
        if ({if_valid, halted} !== {1'b0, 1'b0}) begin
            errors++;
            $display("FAIL halt_exit: valid=%0b halted=%0b, required 0/0", if_valid, halted);
        end
        tick();
        checks++;
        if ({if_valid, if_pc, if_instr, halted} !== {1'b1, 32'h0, w(0), 1'b0}) begin
            errors++;
            $display("FAIL halt_resume: valid=%0b pc=%h instr=%h halted=%0b, required 1/00000000/%h/0",
                     if_valid, if_pc, if_instr, halted, w(0));
        end
        $display("halt_resume: valid=%0b pc=%h instr=%h halted=%0b", if_valid, if_pc, if_instr, halted);
    endtask

    task automatic test_write_collision();
        imem_we = 1'b1; imem_waddr = AW'(1); imem_wdata = 32'hDEAD_BEEF;
        tick();
        imem_we = 1'b0;
        checks++;
        if ({if_pc, if_instr} !== {32'h4, w(1)}) begin
            errors++;
            $display("FAIL collide_old: pc=%h instr=%h, required 00000004/%h", if_pc, if_instr, w(1));
        end
        $display("collide_old: pc=%h instr=%h", if_pc, if_instr);
        redirect = 1'b1; redirect_pc = 32'h4;
        tick();
        redirect = 1'b0;
        tick();
        checks++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h4, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL collide_new: valid=%0b pc=%h instr=%h, required 1/00000004/deadbeef", if_valid, if_pc, if_instr);
        end
        $display("collide_new: valid=%0b pc=%h instr=%h", if_valid, if_pc, if_instr);
        tick();
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL collide_halt: halted=%0b, required 1", halted);
        end
    endtask

    task automatic test_reset_recover();
        stall = 1'b1; rst = 1'b1;
        tick();
        checks++;
        if ({if_valid, halted, if_pc, if_instr} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL rst_recover: valid=%0b halted=%0b pc=%h instr=%h, required all zero",
                     if_valid, halted, if_pc, if_instr);
        end
        $display("rst_recover: valid=%0b halted=%0b pc=%h instr=%h", if_valid, halted, if_pc, if_instr);
        rst = 1'b0; stall = 1'b0;
        tick();
        checks++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0, w(0)}) begin
            errors++;
            $display("FAIL rst_restart: valid=%0b pc=%h instr=%h, required 1/00000000/%h", if_valid, if_pc, if_instr, w(0));
        end
        tick();
        checks++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h4, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL rst_imem_kept: valid=%0b pc=%h instr=%h, required 1/00000004/deadbeef", if_valid, if_pc, if_instr);
        end
        $display("rst_imem_kept: valid=%0b pc=%h instr=%h", if_valid, if_pc, if_instr);
    endtask

    initial begin
        test_reset();
        test_sequential_and_stall();
        test_redirect_bubble();
        test_wrap();
        test_halt();
        test_write_collision();
        test_reset_recover();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
